sequential_divider: RTL and testbench
=====================================

# sequential_divider

Sequential restoring divider: the inverse datapath of the team's sequential Booth multiplier. It divides a WORD_LENGTH-bit dividend by a WORD_LENGTH-bit divisor, one quotient bit per clock, and returns a quotient and a remainder. It sits beside the multiplier in the arithmetic unit and uses the same start/ready handshake style, so a controller can drive either block.

## Interface
- WORD_LENGTH, 16, operand/result width; legal range 4..32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  request; sampled only in IDLE.
- Dividend  in  WORD_LENGTH  numerator; captured on the accepting edge.
- Divisor  in  WORD_LENGTH  denominator; captured on the accepting edge.
- busy  out  1  high from the accepting edge until the result is written; reset 0.
- ready  out  1  one-cycle pulse when results update; reset 0.
- Quotient  out  WORD_LENGTH  registered, held until the next result; reset 0.
- Remainder  out  WORD_LENGTH  registered, held until the next result; reset 0.
- DivByZero  out  1  registered with the results; high if the captured Divisor was 0; reset 0.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: WORD_LENGTH iterations.
  - FIX: sign correction and result write.
- Transitions:
  - IDLE -> CALC when start=1. The edge captures the operand magnitudes, the sign flags, a zero-divisor flag and clears the iteration counter.
  - CALC -> FIX after WORD_LENGTH cycles.
  - FIX -> IDLE unconditionally.
- Each CALC cycle:
  - Shift {R, Q} left one place. R is WORD_LENGTH+1 bits wide.
  - Trial value T = R - D.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise R is restored and Q[0] = 0.
- FIX writes Quotient, Remainder and DivByZero, and pulses ready.
- Divisor 0 runs the full latency without special-casing and forces Quotient = all ones, Remainder = Dividend, DivByZero = 1.
- start while busy is ignored. Operands may change freely after the accepting edge.
- reset asserted mid-operation returns the block to IDLE immediately. All outputs go to 0, and a partial result is never presented.

## Timing
- With start high at edge t0, CALC occupies edges t1..tWORD_LENGTH and FIX is edge tWORD_LENGTH+1.
- ready is high for exactly one cycle after edge t0+WORD_LENGTH+1. Latency is WORD_LENGTH+1 cycles (17 at default).
- busy rises after t0 and falls after tWORD_LENGTH+1, in the same cycle ready rises.
- A new start may be presented in the cycle ready is high (block is in IDLE). It is accepted, giving a throughput of one division per WORD_LENGTH+1 cycles.

## Configuration
- DIVIDER_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are taken at capture.
  - Quotient truncates toward zero and is negated in FIX if the operand signs differ.
  - Remainder takes the sign of Dividend.
  - Overflow case: most-negative / -1 yields Quotient = most-negative, Remainder = 0, no flag.
- DIVIDER_SIGNED_EN undefined: operands are unsigned and FIX only writes results. The sign flags and negation logic are not synthesized.

## Structure
- divider_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the default WORD_LENGTH constant;
  - the iteration counter width, computed as $clog2(WORD_LENGTH+1).
- One natural sub-module: divider_iteration_counter. It is a loadable down-counter with clear on start and a terminal-count flag that drives CALC -> FIX.
- The shift/subtract/restore datapath and the FSM stay in sequential_divider.

## Test plan
- Basic unsigned: 100 / 7 -> Quotient 14, Remainder 2, DivByZero 0, ready exactly 17 cycles after start, busy high 17 cycles.
- Signed (DIVIDER_SIGNED_EN): -100 / 7 -> Quotient 0xFFF2, Remainder 0xFFFE; 100 / -7 -> 0xFFF2, 0x0002; -32768 / -1 -> 0x8000, 0x0000.
- Divide by zero: 1234 / 0 -> Quotient 0xFFFF, Remainder 1234, DivByZero 1, normal latency.
- Handshake:
  - start re-pulsed at cycle 5 with new operands -> ignored; the first result is unchanged.
  - start held high in the ready cycle -> second division accepted with no idle gap.
- Reset mid-operation: reset low at cycle 8 of 17 -> busy, ready, Quotient, Remainder, DivByZero all 0 immediately.
  - After release, 65535 / 1 (unsigned build) -> Quotient 65535, Remainder 0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

   localparam int DEFAULT_WORD_LENGTH = 16;

   function automatic int count_width(input int word_length);
      return $clog2(word_length + 1);
   endfunction

   localparam int COUNT_WIDTH = count_width(DEFAULT_WORD_LENGTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } divider_state_t;

endpackage

// File: rtl/divider_iteration_counter.sv
// Loadable down-counter that paces the divider's CALC phase.
// terminal is high when the count has reached zero.
module divider_iteration_counter
   import divider_pkg::*;
#(
   parameter int WIDTH = COUNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign terminal = (count == '0);

endmodule

// File: rtl/sequential_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Define DIVIDER_SIGNED_EN for two's complement operands (default build is unsigned).
module sequential_divider
   import divider_pkg::*;
#(
   parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] Dividend,
   input  logic [WORD_LENGTH-1:0] Divisor,
   output logic                   busy,
   output logic                   ready,
   output logic [WORD_LENGTH-1:0] Quotient,
   output logic [WORD_LENGTH-1:0] Remainder,
   output logic                   DivByZero
);

   localparam int CNT_W = count_width(WORD_LENGTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_LENGTH - 1);

   divider_state_t state, next_state;
   logic accept, iterate, write_result;

   logic [WORD_LENGTH-1:0] rem_reg, quo_reg, div_reg;
   logic                   zero_div;
   logic [WORD_LENGTH:0]   rem_shift, trial;
   logic [WORD_LENGTH-1:0] quo_shift;
   logic [WORD_LENGTH-1:0] dividend_mag, divisor_mag;
   logic [WORD_LENGTH-1:0] quotient_next, remainder_next;
   logic [CNT_W-1:0]       iter_count;
   logic                   iter_done;

`ifdef DIVIDER_SIGNED_EN
   logic dividend_neg, divisor_neg;
   assign dividend_mag = Dividend[WORD_LENGTH-1] ? -Dividend : Dividend;
   assign divisor_mag  = Divisor[WORD_LENGTH-1]  ? -Divisor  : Divisor;
`else
   assign dividend_mag = Dividend;
   assign divisor_mag  = Divisor;
`endif

   divider_iteration_counter #(
      .WIDTH(CNT_W)
   ) u_iteration_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .enable    (iterate),
      .load_value(LAST_ITER),
      .count     (iter_count),
      .terminal  (iter_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CALC;
         CALC:    if (iter_done) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      accept       = (state == IDLE) && start;
      iterate      = (state == CALC);
      write_result = (state == FIX);
      busy         = (state != IDLE);
   end

   // The stored remainder is always below the divisor, so W bits hold it;
   // the shifted value needs W+1, and bit W of the trial is its sign.
   assign rem_shift = {rem_reg, quo_reg[WORD_LENGTH-1]};
   assign quo_shift = {quo_reg[WORD_LENGTH-2:0], 1'b0};
   assign trial     = rem_shift - {1'b0, div_reg};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         div_reg  <= '0;
         zero_div <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         dividend_neg <= 1'b0;
         divisor_neg  <= 1'b0;
`endif
      end else if (accept) begin
         rem_reg  <= '0;
         quo_reg  <= dividend_mag;
         div_reg  <= divisor_mag;
         zero_div <= (Divisor == '0);
`ifdef DIVIDER_SIGNED_EN
         dividend_neg <= Dividend[WORD_LENGTH-1];
         divisor_neg  <= Divisor[WORD_LENGTH-1];
`endif
      end else if (iterate) begin
         if (!trial[WORD_LENGTH]) begin
            rem_reg <= trial[WORD_LENGTH-1:0];
            quo_reg <= quo_shift | {{(WORD_LENGTH-1){1'b0}}, 1'b1};
         end else begin
            rem_reg <= rem_shift[WORD_LENGTH-1:0];
            quo_reg <= quo_shift;
         end
      end
   end

   // A zero divisor naturally leaves the dividend magnitude in the remainder;
   // only the quotient needs forcing so the sign fix cannot disturb it.
   always_comb begin
      quotient_next  = quo_reg;
      remainder_next = rem_reg;
`ifdef DIVIDER_SIGNED_EN
      if (dividend_neg ^ divisor_neg) quotient_next  = -quo_reg;
      if (dividend_neg)               remainder_next = -rem_reg;
`endif
      if (zero_div) quotient_next = '1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready     <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         ready <= write_result;
         if (write_result) begin
            Quotient  <= quotient_next;
            Remainder <= remainder_next;
            DivByZero <= zero_div;
         end
      end
   end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider against an arithmetic reference model.
// Honours DIVIDER_SIGNED_EN when the design is built signed.
module tb_sequential_divider;

   localparam int W       = 16;
   localparam int LATENCY = W + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, ready, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int vectors = 0;
   int miscompares = 0;

   sequential_divider #(.WORD_LENGTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .Dividend (dividend),
      .Divisor  (divisor),
      .busy     (busy),
      .ready    (ready),
      .Quotient (quotient),
      .Remainder(remainder),
      .DivByZero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic void referenceModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                          output logic [W-1:0] q, output logic [W-1:0] r,
                                          output logic z);
      z = (b == '0);
      if (z) begin
         q = '1;
         r = a;
      end else begin
`ifdef DIVIDER_SIGNED_EN
         if (a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000;
            r = '0;
         end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endfunction

   task automatic idleCycles(input int k);
      start = 1'b0;
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         checkOutput("idle_ready", ready, 1'b0);
         checkOutput("idle_busy", busy, 1'b0);
      end
   endtask

   // Presents start at the current negedge and follows the division to ready.
   // repulse_at > 0 re-asserts start with junk operands at that cycle.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse_at);
      logic [W-1:0] exp_q, exp_r;
      logic         exp_z;
      int           n = 0;
      int           busy_cycles = 0;
      bit           seen = 1'b0;
      referenceModel(a, b, exp_q, exp_r, exp_z);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) checkOutput("ready_pulse_width", ready, 1'b0);
         if (busy) busy_cycles++;
         if (ready) begin
            seen = 1'b1;
         end else begin
            start    = (n == repulse_at);
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
      end
      if (!seen) begin
         checkOutput("ready_timeout", ready, 1'b1);
      end else begin
         checkOutput("latency", n - 1, LATENCY);
         checkOutput("busy_cycles", busy_cycles, LATENCY);
         checkOutput("busy_in_ready_cycle", busy, 1'b0);
         checkOutput("quotient", quotient, exp_q);
         checkOutput("remainder", remainder, exp_r);
         checkOutput("div_by_zero", div_by_zero, exp_z);
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      $display("[TB] sequential_divider bench starting");
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_ready", ready, 1'b0);
      checkOutput("reset_quotient", quotient, '0);
      checkOutput("reset_remainder", remainder, '0);
      checkOutput("reset_div_by_zero", div_by_zero, 1'b0);
      reset = 1'b1;
      idleCycles(2);

      applyStimulus(16'd100, 16'd7, 0);
      idleCycles(2);
      applyStimulus(16'd1234, 16'd0, 0);
      idleCycles(2);
      applyStimulus(16'd500, 16'd3, 5);
      idleCycles(1);

      applyStimulus(16'd40000, 16'd123, 0);
      applyStimulus(16'd999, 16'd1000, 0);
      applyStimulus(16'hFFFF, 16'hFFFF, 0);
      idleCycles(2);

`ifdef DIVIDER_SIGNED_EN
      applyStimulus(16'hFF9C, 16'd7, 0);
      applyStimulus(16'd100, 16'hFFF9, 0);
      applyStimulus(16'h8000, 16'hFFFF, 0);
      applyStimulus(16'hFF9C, 16'hFFF9, 0);
      idleCycles(1);
`endif

      // Reset in the middle of a division must clear every output at once.
      applyStimulus(16'd4321, 16'd0, 0);
      idleCycles(1);
      start    = 1'b1;
      dividend = 16'd5000;
      divisor  = 16'd13;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_ready", ready, 1'b0);
      checkOutput("midreset_quotient", quotient, '0);
      checkOutput("midreset_remainder", remainder, '0);
      checkOutput("midreset_div_by_zero", div_by_zero, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      idleCycles(LATENCY + 2);
      applyStimulus(16'hFFFF, 16'd1, 0);
      idleCycles(1);

      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            default: rb = W'($urandom);
         endcase
         applyStimulus(ra, rb, (i % 3 == 0) ? int'($urandom_range(2, 14)) : 0);
         if ($urandom_range(0, 1) == 1) idleCycles(1);
      end
      idleCycles(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
